// File: rtl/note_recorder.sv
// Beat-synchronous note recorder: captures notes_in into a 64-entry memory and plays it back.
// Define NOTE_RECORDER_LOOP_EN to make playback wrap to the start instead of ending.
module note_recorder #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned NOTE_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              beat,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic [NOTE_W-1:0] notes_in,
    output logic [NOTE_W-1:0] notes_out,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W:0]   length,
    output logic              recording,
    output logic              playing,
    output logic              full,
    output logic              done
);

    localparam int unsigned PtrW = ADDR_W + 1;
    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [PtrW-1:0] DepthP = PtrW'(Depth);

    typedef enum logic [1:0] {StIdle, StRec, StPlay} state_e;

    state_e              state_q, state_d;
    // One extra pointer bit so a full 64-note take still reaches ptr == length at its end.
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic [PtrW-1:0]     len_q, len_d;
    logic [NOTE_W-1:0]   notes_q, notes_d;
    logic                done_q, done_d;
    logic                mem_we;
    logic [NOTE_W-1:0]   mem_q [Depth];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        notes_d = notes_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rec_start) begin
                    state_d = StRec;
                    ptr_d   = '0;
                    len_d   = '0;
                end else if (play_start && (len_q != '0)) begin
                    state_d = StPlay;
                    ptr_d   = '0;
                end
            end
            StRec: begin
                if (stop) begin
                    state_d = StIdle;
                    notes_d = '0;
                    done_d  = 1'b1;
                end else if (beat) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + PtrW'(1);
                    len_d  = len_q + PtrW'(1);
                    if (len_q == DepthP - PtrW'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                    notes_d = '0;
                    done_d  = 1'b1;
                end else if (beat) begin
                    if (ptr_q < len_q) begin
                        notes_d = mem_q[ptr_q[ADDR_W-1:0]];
                        ptr_d   = ptr_q + PtrW'(1);
                    end else begin
`ifdef NOTE_RECORDER_LOOP_EN
                        notes_d = mem_q[0];
                        ptr_d   = PtrW'(1);
`else
                        notes_d = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            len_q   <= '0;
            notes_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            notes_q <= notes_d;
            done_q  <= done_d;
        end
    end

    // No reset on the array: contents deliberately survive resetn.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q[ADDR_W-1:0]] <= notes_in;
        end
    end

    assign notes_out = notes_q;
    assign address   = ptr_q[ADDR_W-1:0];
    assign length    = len_q;
    assign recording = (state_q == StRec);
    assign playing   = (state_q == StPlay);
    assign full      = (len_q == DepthP);
    assign done      = done_q;

endmodule

// File: tb/tb_note_recorder.sv
// Self-checking bench for note_recorder: directed test-plan steps then random traffic,
// all compared against a queue-based model of a recorded take.
module tb_note_recorder;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NOTE_W = 10;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              resetn;
    logic              beat, rec_start, play_start, stop;
    logic [NOTE_W-1:0] notes_in;
    logic [NOTE_W-1:0] notes_out;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W:0]   length;
    logic              recording, playing, full, done;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 record, 2 play; the take is a queue of notes.
    int                mode;
    logic [NOTE_W-1:0] take[$];
    int                pos;
    logic [NOTE_W-1:0] m_notes;
    bit                m_done;

    note_recorder #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W)) dut (
        .clk(clk), .resetn(resetn), .beat(beat), .rec_start(rec_start),
        .play_start(play_start), .stop(stop), .notes_in(notes_in),
        .notes_out(notes_out), .address(address), .length(length),
        .recording(recording), .playing(playing), .full(full), .done(done)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        mode = 0;
        take.delete();
        pos = 0;
        m_notes = '0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input bit b, input bit r, input bit p, input bit s,
                              input logic [NOTE_W-1:0] n);
        m_done = 1'b0;
        if (mode == 0) begin
            if (r) begin
                mode = 1;
                take.delete();
                pos = 0;
            end else if (p && take.size() != 0) begin
                mode = 2;
                pos = 0;
            end
        end else if (s) begin
            mode = 0;
            m_notes = '0;
            m_done = 1'b1;
        end else if (b) begin
            if (mode == 1) begin
                take.push_back(n);
                pos = take.size();
                if (take.size() == DEPTH) begin
                    mode = 0;
                    m_done = 1'b1;
                end
            end else if (pos < take.size()) begin
                m_notes = take[pos];
                pos = pos + 1;
            end else begin
`ifdef NOTE_RECORDER_LOOP_EN
                m_notes = take[0];
                pos = 1;
`else
                m_notes = '0;
                mode = 0;
                m_done = 1'b1;
`endif
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        logic [ADDR_W-1:0] exp_addr;
        logic [ADDR_W:0]   exp_len;
        exp_addr = ADDR_W'(pos % DEPTH);
        exp_len  = (ADDR_W + 1)'(take.size());
        check({tag, ".notes_out"}, 32'(notes_out), 32'(m_notes));
        check({tag, ".address"},   32'(address),   32'(exp_addr));
        check({tag, ".length"},    32'(length),    32'(exp_len));
        check({tag, ".recording"}, 32'(recording), 32'(mode == 1));
        check({tag, ".playing"},   32'(playing),   32'(mode == 2));
        check({tag, ".full"},      32'(full),      32'(take.size() == DEPTH));
        check({tag, ".done"},      32'(done),      32'(m_done));
    endtask

    task automatic step(input string tag, input bit b, input bit r, input bit p, input bit s,
                        input logic [NOTE_W-1:0] n);
        @(negedge clk);
        beat = b; rec_start = r; play_start = p; stop = s; notes_in = n;
        @(posedge clk);
        model_step(b, r, p, s, n);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        beat = 0; rec_start = 0; play_start = 0; stop = 0; notes_in = '0;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        beat = 0; rec_start = 0; play_start = 0; stop = 0; notes_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        @(negedge clk);
        resetn = 1'b1;

        // Reset mid-record with length 5, then play_start must be ignored.
        step("rst_rec", 0, 1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step("rst_beat", 1, 0, 0, 0, NOTE_W'(i + 7));
        check("rst_len5", 32'(length), 32'd5);
        do_reset("rst_mid");
        step("rst_play", 0, 0, 1, 0, '0);
        step("rst_play2", 1, 0, 0, 0, '0);

        // Record 3, stop, play 4 beats.
        step("r3_start", 0, 1, 0, 0, '0);
        step("r3_b0", 1, 0, 0, 0, 10'h001);
        step("r3_b1", 1, 0, 0, 0, 10'h002);
        step("r3_b2", 1, 0, 0, 0, 10'h004);
        step("r3_stop", 0, 0, 0, 1, '0);
        step("r3_idle", 0, 0, 0, 0, '0);
        step("p3_start", 1, 0, 1, 0, '0);
        for (int i = 0; i < 4; i++) step("p3_beat", 1, 0, 0, 0, '0);
        step("p3_stop", 0, 0, 0, 1, '0);
        step("p3_idle", 0, 0, 0, 0, '0);

        // Full 64-note recording plus an extra beat.
        step("full_start", 1, 1, 0, 0, '0);
        for (int i = 0; i < 65; i++) step("full_beat", 1, 0, 0, 0, NOTE_W'(i));
        check("full_flag", 32'(full), 32'd1);
        check("full_len", 32'(length), 32'd64);
        // Play the whole take to its end.
        step("pf_start", 0, 0, 1, 0, '0);
        for (int i = 0; i < 66; i++) step("pf_beat", 1, 0, 0, 0, '0);
        step("pf_stop", 0, 0, 0, 1, '0);

        // Stop/beat collision at length 2.
        step("col_start", 0, 1, 0, 0, '0);
        step("col_b0", 1, 0, 0, 0, 10'h0AA);
        step("col_b1", 1, 0, 0, 0, 10'h155);
        step("col_hit", 1, 0, 0, 1, 10'h3FF);
        check("col_len2", 32'(length), 32'd2);
        // Playback of that take (loops when the loop build is enabled).
        step("loop_start", 0, 0, 1, 0, '0);
        for (int i = 0; i < 5; i++) step("loop_beat", 1, 0, 0, 0, '0);
        step("loop_stop", 0, 0, 0, 1, '0);
        step("loop_idle_stop", 0, 0, 0, 1, '0);

        // Strobe arbitration.
        step("arb_both", 0, 1, 1, 0, '0);
        check("arb_rec", 32'(recording), 32'd1);
        step("arb_play_in_rec", 1, 0, 1, 0, 10'h123);
        step("arb_rec_in_rec", 1, 1, 0, 0, 10'h321);
        step("arb_stop", 0, 0, 0, 1, '0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit b, r, p, s;
            b = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 39) == 0);
            p = ($urandom_range(0, 14) == 0);
            s = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
            else step("rnd", b, r, p, s, NOTE_W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
